hilo_mdu: RTL

//  Multiply/divide unit with HI/LO registers, in the E stage of the P7 pipeline.

---
 rtl/mdu_pkg.sv | 16 +
 rtl/mdu_arith.sv | 59 +++++
 rtl/hilo_mdu.sv | 110 +++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared multiply/divide unit definitions.
// Holds the HI/LO operation encoding consumed by hilo_mdu and produced by the
// ctrl decoder; both sides must agree on these values.
package mdu_pkg;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MFHI  = 4'd7;
  localparam logic [3:0] MDU_MFLO  = 4'd8;

endpackage

// File: rtl/mdu_arith.sv
// Combinational arithmetic core for the multiply/divide unit.
// Ports: op (MDU_* code), rs/rt operands in; res_hi/res_lo result halves and
//   res_valid (low for divide-by-zero or non-arithmetic ops) out.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        res_valid
);

  // Signed ops work on sign-extended 64-bit operands. This also keeps
  // INT_MIN / -1 well defined: the quotient simply wraps when truncated.
  logic signed [63:0] sa;
  logic signed [63:0] sb;
  logic        [63:0] ua;
  logic        [63:0] ub;

  assign sa = {{32{rs[31]}}, rs};
  assign sb = {{32{rt[31]}}, rt};
  assign ua = {32'd0, rs};
  assign ub = {32'd0, rt};

  always_comb begin
    res_hi    = 32'd0;
    res_lo    = 32'd0;
    res_valid = 1'b0;
    case (op)
      MDU_MULT: begin
        {res_hi, res_lo} = sa * sb;
        res_valid        = 1'b1;
      end
      MDU_MULTU: begin
        {res_hi, res_lo} = ua * ub;
        res_valid        = 1'b1;
      end
      MDU_DIV: begin
        // Divide by zero leaves HI/LO untouched, so no result is produced.
        if (rt != 32'd0) begin
          res_lo    = 32'(sa / sb);
          res_hi    = 32'(sa % sb);
          res_valid = 1'b1;
        end
      end
      MDU_DIVU: begin
        if (rt != 32'd0) begin
          res_lo    = rs / rt;
          res_hi    = rs % rt;
          res_valid = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/hilo_mdu.sv
// Multiply/divide unit with HI/LO registers (E stage).
// Ports: clk, reset (sync, active-high), start/op/rs_val/rt_val/req in;
//   busy (to stall unit hl_busy) and hl_out (combinational HI/LO read) out.
module hilo_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        req,
  output logic        busy,
  output logic [31:0] hl_out
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             pend_valid_q, pend_valid_d;

  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_valid;
  logic        accept;

  mdu_arith u_arith (
    .op        (op),
    .rs        (rs_val),
    .rt        (rt_val),
    .res_hi    (res_hi),
    .res_lo    (res_lo),
    .res_valid (res_valid)
  );

  assign busy   = (cnt_q != '0);
  assign accept = start && !req && !busy;

  always_comb begin
    cnt_d        = cnt_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    pend_hi_d    = pend_hi_q;
    pend_lo_d    = pend_lo_q;
    pend_valid_d = pend_valid_q;

    // Countdown runs regardless of req: an accepted op always completes.
    if (busy) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1) && pend_valid_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end

    // accept implies !busy, so this never collides with the commit above.
    if (accept) begin
      case (op)
        MDU_MULT, MDU_MULTU: begin
          pend_hi_d    = res_hi;
          pend_lo_d    = res_lo;
          pend_valid_d = 1'b1;
          cnt_d        = CNT_W'(MULT_CYCLES);
        end
        MDU_DIV, MDU_DIVU: begin
          pend_hi_d    = res_hi;
          pend_lo_d    = res_lo;
          pend_valid_d = res_valid;
          cnt_d        = CNT_W'(DIV_CYCLES);
        end
        MDU_MTHI: hi_d = rs_val;
        MDU_MTLO: lo_d = rs_val;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q        <= '0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      pend_hi_q    <= 32'd0;
      pend_lo_q    <= 32'd0;
      pend_valid_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      pend_hi_q    <= pend_hi_d;
      pend_lo_q    <= pend_lo_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  always_comb begin
    hl_out = 32'd0;
    if (op == MDU_MFHI) hl_out = hi_q;
    else if (op == MDU_MFLO) hl_out = lo_q;
  end

endmodule
